// File: rtl/sparse_pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sparse_pe                                                       |
// | Purpose  : Sparse convolution processing element. Forms the channel-      |
// |            matched Cartesian product of one compressed IA pixel column    |
// |            and one compressed weight bundle, one pair per cycle through a |
// |            single registered multiplier, and accumulates each product     |
// |            into an OA buffer indexed by (output row, output channel).     |
// | Ports    : i_clk / i_rst_n (async, active-low)                            |
// |            i_start (level), i_accumulate (0 = clear OA at start)          |
// |            i_ia_h, i_ia_data[], i_ia_c_idx[], i_ia_len  : IA bundle       |
// |            i_w_data[], i_w_c_idx[], i_w_r_idx[], i_w_k_idx[], i_w_len     |
// |            o_busy (PROC/DRAIN), o_finish (DONE)                           |
// |            o_oa[row*N_K + k] : signed accumulators                        |
// | Config   : define PE_SAT_EN for saturating accumulation; otherwise the    |
// |            accumulators wrap as two's complement.                         |
// | Revision : 1.0 - first computing release                                  |
// +----------------------------------------------------------------------------+
module sparse_pe #(
    parameter int IA_DW  = 8,
    parameter int W_DW   = 8,
    parameter int ACC_DW = 24,
    parameter int N_IA   = 16,
    parameter int N_W    = 32,
    parameter int N_C    = 64,
    parameter int N_ROW  = 8,
    parameter int N_K    = 16,
    parameter int N_R    = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_accumulate,
    input  logic [$clog2(N_ROW)-1:0]  i_ia_h,
    input  logic [IA_DW-1:0]          i_ia_data  [N_IA],
    input  logic [$clog2(N_C)-1:0]    i_ia_c_idx [N_IA],
    input  logic [$clog2(N_IA):0]     i_ia_len,
    input  logic [W_DW-1:0]           i_w_data   [N_W],
    input  logic [$clog2(N_C)-1:0]    i_w_c_idx  [N_W],
    input  logic [$clog2(N_R)-1:0]    i_w_r_idx  [N_W],
    input  logic [$clog2(N_K)-1:0]    i_w_k_idx  [N_W],
    input  logic [$clog2(N_W):0]      i_w_len,
    output logic                      o_busy,
    output logic                      o_finish,
    output logic [ACC_DW-1:0]         o_oa       [N_ROW*N_K]
);

    localparam int CW   = $clog2(N_C);
    localparam int RW   = $clog2(N_R);
    localparam int KW   = $clog2(N_K);
    localparam int HW   = $clog2(N_ROW);
    localparam int IAW  = $clog2(N_IA);
    localparam int WW   = $clog2(N_W);
    localparam int N_OA = N_ROW * N_K;
    localparam int OAW  = $clog2(N_OA);
    localparam int PW   = IA_DW + W_DW;
    // One extra bit so ia_h + r_idx can exceed N_ROW-1 without wrapping.
    localparam int RSW  = ((HW > RW) ? HW : RW) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROC  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;

    // Captured bundle
    logic [HW-1:0]       r_ia_h;
    logic [IA_DW-1:0]    r_ia_data  [N_IA];
    logic [CW-1:0]       r_ia_c_idx [N_IA];
    logic [IAW:0]        r_ia_len;
    logic [W_DW-1:0]     r_w_data   [N_W];
    logic [CW-1:0]       r_w_c_idx  [N_W];
    logic [RW-1:0]       r_w_r_idx  [N_W];
    logic [KW-1:0]       r_w_k_idx  [N_W];
    logic [WW:0]         r_w_len;

    // Pair issue counters (i outer, j inner)
    logic [IAW-1:0]      r_i;
    logic [WW-1:0]       r_j;

    // Product stage
    logic                r_prod_vld;
    logic [ACC_DW-1:0]   r_prod;
    logic [OAW-1:0]      r_prod_idx;

    logic [IAW:0]              w_ia_len_clamp;
    logic [WW:0]               w_w_len_clamp;
    logic                      w_capture;
    logic                      w_clear;
    logic signed [PW-1:0]      w_prod_full;
    logic signed [ACC_DW-1:0]  w_prod_ext;
    logic [RSW-1:0]            w_row;
    logic                      w_hit;
    logic [OAW-1:0]            w_idx;
    logic                      w_last_i;
    logic                      w_last_j;

    assign w_ia_len_clamp = (i_ia_len > (IAW+1)'(N_IA)) ? (IAW+1)'(N_IA) : i_ia_len;
    assign w_w_len_clamp  = (i_w_len  > (WW+1)'(N_W))   ? (WW+1)'(N_W)   : i_w_len;

    assign w_capture = (r_state == S_IDLE) && i_start;
    assign w_clear   = w_capture && !i_accumulate;

    assign w_prod_full = $signed(r_ia_data[r_i]) * $signed(r_w_data[r_j]);
    assign w_prod_ext  = ACC_DW'(w_prod_full);

    assign w_row = RSW'(r_ia_h) + RSW'(r_w_r_idx[r_j]);
    assign w_hit = (r_ia_c_idx[r_i] == r_w_c_idx[r_j]) && (w_row < RSW'(N_ROW));
    assign w_idx = OAW'(w_row) * OAW'(N_K) + OAW'(r_w_k_idx[r_j]);

    assign w_last_i = ({1'b0, r_i} == (r_ia_len - (IAW+1)'(1)));
    assign w_last_j = ({1'b0, r_j} == (r_w_len  - (WW+1)'(1)));

    // Bundle capture; contents only matter once a start has been accepted,
    // so no reset is needed here.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_ia_h     <= i_ia_h;
            r_ia_data  <= i_ia_data;
            r_ia_c_idx <= i_ia_c_idx;
            r_ia_len   <= w_ia_len_clamp;
            r_w_data   <= i_w_data;
            r_w_c_idx  <= i_w_c_idx;
            r_w_r_idx  <= i_w_r_idx;
            r_w_k_idx  <= i_w_k_idx;
            r_w_len    <= w_w_len_clamp;
        end
    end

    // Control FSM and product stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_finish   <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_prod_vld <= 1'b0;
            r_prod     <= '0;
            r_prod_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_prod_vld <= 1'b0;
                    if (i_start) begin
                        r_i    <= '0;
                        r_j    <= '0;
                        o_busy <= 1'b1;
                        if ((w_ia_len_clamp == '0) || (w_w_len_clamp == '0)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_PROC;
                        end
                    end
                end
                S_PROC: begin
                    r_prod_vld <= w_hit;
                    r_prod     <= w_prod_ext;
                    r_prod_idx <= w_idx;
                    if (w_last_j) begin
                        r_j <= '0;
                        if (w_last_i) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_i <= r_i + IAW'(1);
                        end
                    end else begin
                        r_j <= r_j + WW'(1);
                    end
                end
                S_DRAIN: begin
                    // The final product is absorbed by the OA stage on this edge.
                    r_prod_vld <= 1'b0;
                    o_busy     <= 1'b0;
                    o_finish   <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (!i_start) begin
                        o_finish <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    function automatic logic [ACC_DW-1:0] acc_add(input logic [ACC_DW-1:0] a,
                                                  input logic [ACC_DW-1:0] b);
`ifdef PE_SAT_EN
        logic [ACC_DW:0] sum;
        sum = {a[ACC_DW-1], a} + {b[ACC_DW-1], b};
        // Overflow when the two top bits of the widened sum disagree.
        if (sum[ACC_DW] != sum[ACC_DW-1]) begin
            acc_add = sum[ACC_DW] ? {1'b1, {(ACC_DW-1){1'b0}}}
                                  : {1'b0, {(ACC_DW-1){1'b1}}};
        end else begin
            acc_add = sum[ACC_DW-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    // OA buffer: single-cycle read-modify-write, so consecutive hits on the
    // same entry see each other's result without forwarding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < N_OA; n++) begin
                o_oa[n] <= '0;
            end
        end else if (w_clear) begin
            for (int n = 0; n < N_OA; n++) begin
                o_oa[n] <= '0;
            end
        end else if (r_prod_vld) begin
            o_oa[r_prod_idx] <= acc_add(o_oa[r_prod_idx], r_prod);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sparse_pe                                                    |
// | Purpose  : Self-checking bench for sparse_pe. Two instances share the     |
// |            stimulus: the default configuration and one with ACC_DW=16 so  |
// |            accumulator overflow is reachable.                             |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_sparse_pe;

    localparam int N_IA = 16;
    localparam int N_W  = 32;
    localparam int N_OA = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        accumulate = 1'b0;
    logic [2:0]  ia_h;
    logic [7:0]  ia_data [N_IA];
    logic [5:0]  ia_c    [N_IA];
    logic [4:0]  ia_len;
    logic [7:0]  w_data  [N_W];
    logic [5:0]  w_c     [N_W];
    logic [1:0]  w_r     [N_W];
    logic [3:0]  w_k     [N_W];
    logic [5:0]  w_len;

    logic        busy24, fin24, busy16, fin16;
    logic [23:0] oa24 [N_OA];
    logic [15:0] oa16 [N_OA];

    // Expected state
    longint exp24 [N_OA];
    longint exp16 [N_OA];
    bit     exp_busy   = 1'b0;
    bit     exp_finish = 1'b0;
    bit     chk_en     = 1'b0;
    bit     chk_oa     = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sparse_pe u_dut24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_accumulate(accumulate),
        .i_ia_h(ia_h), .i_ia_data(ia_data), .i_ia_c_idx(ia_c), .i_ia_len(ia_len),
        .i_w_data(w_data), .i_w_c_idx(w_c), .i_w_r_idx(w_r), .i_w_k_idx(w_k),
        .i_w_len(w_len), .o_busy(busy24), .o_finish(fin24), .o_oa(oa24)
    );

    sparse_pe #(.ACC_DW(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_accumulate(accumulate),
        .i_ia_h(ia_h), .i_ia_data(ia_data), .i_ia_c_idx(ia_c), .i_ia_len(ia_len),
        .i_w_data(w_data), .i_w_c_idx(w_c), .i_w_r_idx(w_r), .i_w_k_idx(w_k),
        .i_w_len(w_len), .o_busy(busy16), .o_finish(fin16), .o_oa(oa16)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint acc_add(input longint a, input longint b, input int w);
        longint mx;
        longint mn;
        longint s;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s  = a + b;
`ifdef PE_SAT_EN
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
`else
        if (s > mx) s = s - (longint'(1) <<< w);
        else if (s < mn) s = s + (longint'(1) <<< w);
`endif
        return s;
    endfunction

    task automatic model_apply(input bit acc, input int ia_n, input int w_n);
        int     row;
        int     idx;
        longint p;
        if (!acc) begin
            foreach (exp24[n]) begin
                exp24[n] = 0;
                exp16[n] = 0;
            end
        end
        for (int i = 0; i < ia_n; i++) begin
            for (int j = 0; j < w_n; j++) begin
                if (ia_c[i] == w_c[j]) begin
                    row = int'(ia_h) + int'(w_r[j]);
                    if (row < 8) begin
                        idx = row * 16 + int'(w_k[j]);
                        p = longint'($signed(ia_data[i])) * longint'($signed(w_data[j]));
                        exp24[idx] = acc_add(exp24[idx], p, 24);
                        exp16[idx] = acc_add(exp16[idx], p, 16);
                    end
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        int f24;
        int f16;
        if (chk_en) begin
            check("busy24",   longint'(busy24), longint'(exp_busy));
            check("finish24", longint'(fin24),  longint'(exp_finish));
            check("busy16",   longint'(busy16), longint'(exp_busy));
            check("finish16", longint'(fin16),  longint'(exp_finish));
            if (chk_oa) begin
                f24 = -1;
                f16 = -1;
                for (int n = 0; n < N_OA; n++) begin
                    if (f24 < 0 && longint'($signed(oa24[n])) != exp24[n]) f24 = n;
                    if (f16 < 0 && longint'($signed(oa16[n])) != exp16[n]) f16 = n;
                end
                n_checks += 2;
                if (f24 >= 0) begin
                    n_fail++;
                    $display("FAIL oa24[%0d]: got %0d, required %0d", f24, $signed(oa24[f24]), exp24[f24]);
                end
                if (f16 >= 0) begin
                    n_fail++;
                    $display("FAIL oa16[%0d]: got %0d, required %0d", f16, $signed(oa16[f16]), exp16[f16]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_job();
        ia_h   = '0;
        ia_len = '0;
        w_len  = '0;
        foreach (ia_data[n]) begin
            ia_data[n] = '0;
            ia_c[n]    = '0;
        end
        foreach (w_data[n]) begin
            w_data[n] = '0;
            w_c[n]    = '0;
            w_r[n]    = '0;
            w_k[n]    = '0;
        end
    endtask

    task automatic set_ia(input int n, input int d, input int c);
        ia_data[n] = 8'(d);
        ia_c[n]    = 6'(c);
    endtask

    task automatic set_w(input int n, input int d, input int c, input int r, input int k);
        w_data[n] = 8'(d);
        w_c[n]    = 6'(c);
        w_r[n]    = 2'(r);
        w_k[n]    = 4'(k);
    endtask

    // Inputs are garbage outside the capture edge; the DUT must ignore them.
    task automatic scramble();
        foreach (ia_data[n]) begin
            ia_data[n] = 8'($urandom);
            ia_c[n]    = 6'($urandom);
        end
        foreach (w_data[n]) begin
            w_data[n] = 8'($urandom);
            w_c[n]    = 6'($urandom);
            w_r[n]    = 2'($urandom);
            w_k[n]    = 4'($urandom);
        end
        ia_h       = 3'($urandom);
        ia_len     = 5'($urandom);
        w_len      = 6'($urandom);
        accumulate = 1'($urandom);
    endtask

    task automatic setup_job1();
        clear_job();
        ia_h   = 3'd2;
        ia_len = 5'd2;
        set_ia(0, 5, 3);
        set_ia(1, -2, 7);
        w_len = 6'd3;
        set_w(0, 3, 3, 1, 4);
        set_w(1, 4, 7, 0, 9);
        set_w(2, 6, 1, 0, 0);
    endtask

    // Start sampled at edge T; finish expected after edge T+L+1.
    task automatic run_job(input bit acc, input int hold);
        int ia_n;
        int w_n;
        int L;
        accumulate = acc;
        start      = 1'b1;
        @(posedge clk);
        ia_n = (int'(ia_len) > N_IA) ? N_IA : int'(ia_len);
        w_n  = (int'(w_len)  > N_W)  ? N_W  : int'(w_len);
        L    = ia_n * w_n;
        model_apply(acc, ia_n, w_n);
        #1;
        chk_oa     = 1'b0;
        exp_busy   = 1'b1;
        exp_finish = 1'b0;
        scramble();
        repeat (L) @(posedge clk);
        @(posedge clk);
        #1;
        exp_busy   = 1'b0;
        exp_finish = 1'b1;
        chk_oa     = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        exp_finish = 1'b0;
    endtask

    function automatic int count_nonzero();
        int c;
        c = 0;
        for (int n = 0; n < N_OA; n++) begin
            if (oa24[n] != '0) c++;
            if (oa16[n] != '0) c++;
        end
        return c;
    endfunction

    initial begin
        foreach (exp24[n]) begin
            exp24[n] = 0;
            exp16[n] = 0;
        end
        clear_job();

        // Reset asserted with start held high
        #2;
        rst_n = 1'b0;
        setup_job1();
        start = 1'b1;
        #1;
        chk_en = 1'b1;
        chk_oa = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_finish", longint'(fin24), 0);
        check("rst_busy",   longint'(busy24), 0);
        check("rst_oa_nonzero_count", longint'(count_nonzero()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Job A: basic product, clear
        run_job(1'b0, 0);
        check("A_oa24_52", longint'($signed(oa24[52])), 15);
        check("A_oa24_41", longint'($signed(oa24[41])), -8);
        check("A_oa16_52", longint'($signed(oa16[52])), 15);
        check("A_oa24_0",  longint'($signed(oa24[0])), 0);

        // Job B: same bundles accumulated, start held in DONE
        setup_job1();
        run_job(1'b1, 3);
        check("B_oa24_52", longint'($signed(oa24[52])), 30);
        check("B_oa24_41", longint'($signed(oa24[41])), -16);

        // Job C: row overflow dropped
        clear_job();
        ia_h = 3'd7; ia_len = 5'd1; set_ia(0, 9, 5);
        w_len = 6'd2; set_w(0, 4, 5, 2, 3); set_w(1, 2, 5, 0, 1);
        run_job(1'b1, 0);
        check("C_oa24_113", longint'($signed(oa24[113])), 18);
        check("C_oa24_52",  longint'($signed(oa24[52])), 30);

        // Job D: ia_len=0, accumulate keeps OA
        clear_job();
        w_len = 6'd3; set_w(0, 1, 0, 0, 0);
        run_job(1'b1, 0);
        check("D_oa24_52", longint'($signed(oa24[52])), 30);

        // Job E: w_len=0, clear
        clear_job();
        ia_len = 5'd2; set_ia(0, 1, 0);
        run_job(1'b0, 0);
        check("E_oa24_52",  longint'($signed(oa24[52])), 0);
        check("E_oa24_113", longint'($signed(oa24[113])), 0);

        // Job F: 127*127 three times back-to-back at index 0
        clear_job();
        ia_len = 5'd1; set_ia(0, 127, 0);
        w_len = 6'd3;
        for (int j = 0; j < 3; j++) set_w(j, 127, 0, 0, 0);
        run_job(1'b0, 0);
        check("F_oa24_0", longint'($signed(oa24[0])), 48387);
`ifdef PE_SAT_EN
        check("F_oa16_0", longint'($signed(oa16[0])), 32767);
`else
        check("F_oa16_0", longint'($signed(oa16[0])), -17149);
`endif

        // Job G: w_len clamped from 40 to 32, some rows dropped
        clear_job();
        ia_h = 3'd6; ia_len = 5'd1; set_ia(0, -3, 1);
        w_len = 6'd40;
        for (int j = 0; j < N_W; j++) set_w(j, j - 10, (j % 5 == 0) ? 2 : 1, j % 3, j % 16);
        run_job(1'b0, 0);

        // Job H: mixed signs and channels, accumulated on top of G
        clear_job();
        ia_h = 3'd1; ia_len = 5'd4;
        set_ia(0, 10, 2); set_ia(1, -7, 3); set_ia(2, 127, 2); set_ia(3, -128, 9);
        w_len = 6'd5;
        set_w(0, -128, 2, 0, 15); set_w(1, 5, 3, 1, 0); set_w(2, 1, 9, 2, 7);
        set_w(3, -1, 2, 1, 15);   set_w(4, 3, 4, 0, 2);
        run_job(1'b1, 1);

        // Job I: long job interrupted by reset mid-PROC
        clear_job();
        ia_h = 3'd3; ia_len = 5'd16; w_len = 6'd32;
        for (int i = 0; i < N_IA; i++) set_ia(i, int'($urandom_range(0, 255)) - 128, i % 4);
        for (int j = 0; j < N_W; j++) set_w(j, int'($urandom_range(0, 255)) - 128, j % 4, j % 3, j % 16);
        accumulate = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        chk_oa     = 1'b0;
        exp_busy   = 1'b1;
        exp_finish = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("I_rst_busy",   longint'(busy24), 0);
        check("I_rst_finish", longint'(fin24), 0);
        check("I_rst_oa_nonzero_count", longint'(count_nonzero()), 0);
        foreach (exp24[n]) begin
            exp24[n] = 0;
            exp16[n] = 0;
        end
        exp_busy = 1'b0;
        chk_oa   = 1'b1;
        start    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Restart after reset completes normally
        setup_job1();
        run_job(1'b0, 0);
        check("J_oa24_52", longint'($signed(oa24[52])), 15);
        check("J_oa24_41", longint'($signed(oa24[41])), -8);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
